// File: rtl/counter_arb_pkg.sv
// Shared types and defaults for the counter arbiter: FSM state encoding,
// default widths and the modulo-increment helper used for the round-robin pointer.
package counter_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int DATA_W = 5;
    localparam int CNT_W  = 6;

    // Next requester index, wrapping at n (n need not be a power of two).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/counter_arbiter_rr_select.sv
// Combinational rotate-priority picker: returns the first asserted request
// at or after the pointer, wrapping modulo NUM_REQ.
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W:0]   w_sum  [NUM_REQ];
    logic [IDX_W-1:0] w_cand [NUM_REQ];
    logic [NUM_REQ-1:0] w_hit;

    // Candidate gi is the requester gi positions after the pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign w_sum[gi]  = {1'b0, ptr} + (IDX_W+1)'(gi);
        assign w_cand[gi] = (w_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                            ? IDX_W'(w_sum[gi] - (IDX_W+1)'(NUM_REQ))
                            : IDX_W'(w_sum[gi]);
        assign w_hit[gi]  = req[w_cand[gi]];
    end

    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                valid = 1'b1;
                index = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one external loadable up-counter to NUM_REQ
// requesters: load a start value, count K cycles, hand back the final value.
module counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = counter_arb_pkg::DATA_W,
    parameter int CNT_W   = counter_arb_pkg::CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*CNT_W-1:0]  req_count,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         result,
    output logic                      busy,
    output logic                      cnt_load,
    output logic                      cnt_en,
    output logic [DATA_W-1:0]         cnt_data,
    input  logic [DATA_W-1:0]         cnt_value
);

    import counter_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         r_state, w_next_state;
    logic [IDX_W-1:0]   r_ptr, r_idx, w_sel_idx;
    logic               w_sel_valid, w_abort;
    logic [DATA_W-1:0]  r_data, r_result;
    logic [CNT_W-1:0]   r_count, r_remaining;
    logic [DATA_W-1:0]  w_req_data  [NUM_REQ];
    logic [CNT_W-1:0]   w_req_count [NUM_REQ];
    logic [NUM_REQ-1:0] w_idx_hot;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req_data[gi]  = req_data[gi*DATA_W +: DATA_W];
        assign w_req_count[gi] = req_count[gi*CNT_W +: CNT_W];
        assign w_idx_hot[gi]   = (r_idx == IDX_W'(gi));
    end

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_sel_valid),
        .index (w_sel_idx)
    );

    // The granted requester letting go mid-transaction kills it immediately.
    assign w_abort = ((r_state == LOAD) || (r_state == COUNT)) && !req[r_idx];

    always_comb begin
        w_next_state = r_state;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_data     = '0;
        case (r_state)
            IDLE: begin
                if (w_sel_valid) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                cnt_data = r_data;
                if (w_abort) begin
                    w_next_state = IDLE;
                end else begin
                    cnt_load     = 1'b1;
                    w_next_state = (r_count == '0) ? DONE : COUNT;
                end
            end
            COUNT: begin
                if (w_abort) begin
                    w_next_state = IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (r_remaining == CNT_W'(1)) begin
                        w_next_state = DONE;
                    end
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_result    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_sel_valid) begin
                        r_idx   <= w_sel_idx;
                        r_data  <= w_req_data[w_sel_idx];
                        r_count <= w_req_count[w_sel_idx];
                    end
                end
                LOAD: begin
                    if (w_abort) begin
                        r_ptr <= IDX_W'(wrap_inc(int'(r_idx), NUM_REQ));
                    end else begin
                        r_remaining <= r_count;
                    end
                end
                COUNT: begin
                    if (w_abort) begin
                        r_ptr <= IDX_W'(wrap_inc(int'(r_idx), NUM_REQ));
                    end else begin
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                end
                DONE: begin
                    r_result <= cnt_value;
                    r_ptr    <= IDX_W'(wrap_inc(int'(r_idx), NUM_REQ));
                end
                default: begin
                    r_ptr <= r_ptr;
                end
            endcase
        end
    end

    assign gnt    = (r_state != IDLE) ? w_idx_hot : '0;
    assign done   = (r_state == DONE) ? w_idx_hot : '0;
    assign busy   = (r_state != IDLE);
    assign result = r_result;

endmodule

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 5-bit loadable up-counter between NUM_REQ requesters.
- A granted requester gets one transaction: load a start value, count up a requested number of cycles, then receive the final counter value.
- The block sits between the requesters and the counter's load/en/data_in/counter pins.
- The counter keeps its own reset; this block never drives it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 5, counter width; must match the counter instance.
- CNT_W, 6, width of the per-request increment count (max 2**CNT_W-1 increments).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; must be held high until done, or the transaction aborts.
- req_data  input  NUM_REQ*DATA_W  packed start values; slice i belongs to requester i.
- req_count  input  NUM_REQ*CNT_W  packed increment counts; slice i belongs to requester i.
- gnt  output  NUM_REQ  one-hot; high for the granted requester from the LOAD state through the DONE state.
- done  output  NUM_REQ  one-cycle pulse to the granted requester in the DONE state.
- result  output  DATA_W  counter value captured in DONE; held until the next DONE.
- busy  output  1  high in any state other than IDLE.
- cnt_load  output  1  drives the counter's load pin.
- cnt_en  output  1  drives the counter's en pin.
- cnt_data  output  DATA_W  drives the counter's data_in pin.
- cnt_value  input  DATA_W  counter output, fed back.

Behaviour:
- Reset (rst=1 at a clock edge) takes effect at that edge:
  - state=IDLE, rr pointer=0.
  - gnt=0, done=0, result=0, busy=0, cnt_load=0, cnt_en=0, cnt_data=0.
  - Reset in mid-transaction drops it with no done pulse.
- States: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - If any req is high, select the first requester at or after the pointer, wrapping modulo NUM_REQ.
  - Latch its index, data slice and count slice, then go to LOAD.
  - With no req, stay in IDLE.
- LOAD (exactly 1 cycle):
  - cnt_load=1, cnt_data=latched data, cnt_en=0.
  - Next state is DONE if the latched count is 0, otherwise COUNT with remaining=count.
- COUNT:
  - cnt_en=1 and remaining decrements each cycle.
  - When remaining==1, go to DONE.
  - This gives exactly count increments.
- DONE (1 cycle):
  - done[idx]=1; result<=cnt_value, so result equals start value + count mod 2**DATA_W.
  - pointer<=(idx+1) mod NUM_REQ; go to IDLE.
- Latency: a transaction with count K keeps busy high for K+2 cycles (LOAD, K COUNT cycles, DONE), plus 1 arbitration cycle in IDLE.
- Outputs:
  - cnt_load, cnt_en and cnt_data are combinational from state and latched registers.
  - cnt_data=0 outside LOAD.
- Abort:
  - If req[idx]=0 in any LOAD or COUNT cycle, cnt_load and cnt_en are forced to 0 in that same cycle.
  - Next state is IDLE and the pointer advances past idx; done is not pulsed and result is unchanged.
- Counter wrap-around (31->0) is legal and is not flagged.
- Requests that arrive while busy wait. Req and data changes from non-granted requesters have no effect on the active transaction.
- Back-to-back: after DONE, IDLE arbitrates in the next cycle. The last-served requester has lowest priority.
- Changing req_data or req_count after grant has no effect, because the values are latched in IDLE.

Decomposition:
- Package counter_arb_pkg:
  - state enum type arb_state_t {IDLE, LOAD, COUNT, DONE}.
  - Default width constants DATA_W=5 and CNT_W=6.
- One sub-module, rr_select: a combinational rotate-priority picker.
  - Inputs: req and pointer.
  - Outputs: valid and index.
  - It is instantiated once in counter_arbiter.

Test Plan:
- Single request: req[0] with data=3, count=4 -> gnt[0] for 6 cycles, cnt_en high 4 cycles, done[0] pulse, result=7.
- Round-robin: req=4'b1111 held, all count=0 -> grant order 0,1,2,3,0. Each transaction shows busy=1 for 2 cycles.
- Wrap-around: data=28, count=6 -> result=2, with no glitch on cnt_load during COUNT.
- Zero count: data=17, count=0 -> LOAD then DONE, cnt_en never high, result=17.
- Abort: req[2] data=5, count=10, req dropped after 3 COUNT cycles -> cnt_en low that cycle, no done[2], counter holds 8, result unchanged. Next grant goes to requester 3 if it is requesting.
- Reset mid-COUNT: rst=1 for 1 cycle -> all outputs 0 after the edge. The pointer restarts at 0, so req=4'b1010 next grants 1.
